// File: rtl/apb_req_arbiter_pkg.sv
// Shared FSM encoding and index helpers for apb_req_arbiter and its round-robin picker.
package apb_req_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } arb_state_e;

   // Next requester index after idx, wrapping modulo n.
   function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/apb_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module apb_rr_picker #(
   parameter int NUM_REQ = 4,
   parameter int PW      = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [PW-1:0]      ptr_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [PW-1:0]      idx_o
);

   logic [PW-1:0] cand;

   // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      idx_o = '0;
      cand  = '0;
      // Scan from the farthest offset to the nearest so the requester closest to ptr wins last.
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         cand = PW'((int'(ptr_i) + k) % NUM_REQ);
         if (req_i[cand]) idx_o = cand;
      end
      gnt_o = (|req_i) ? (NUM_REQ'(1) << idx_o) : '0;
   end

endmodule

// File: rtl/apb_req_arbiter.sv
// Round-robin front end sharing one apb_master among NUM_REQ requesters.
// Optional grant locking for back-to-back transfers is enabled by defining APB_ARB_LOCK_EN.
module apb_req_arbiter
   import apb_req_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int AW      = 32,
   parameter int DW      = 32
) (
   input  logic                  PCLK,
   input  logic                  PRESETn,
   input  logic [NUM_REQ-1:0]    REQ,
   input  logic [NUM_REQ-1:0]    REQ_WRITE,
   input  logic [NUM_REQ*AW-1:0] REQ_ADDR,
   input  logic [NUM_REQ*DW-1:0] REQ_WDATA,
   input  logic [NUM_REQ-1:0]    REQ_LOCK,
   output logic [NUM_REQ-1:0]    GNT,
   output logic [NUM_REQ-1:0]    DONE,
   output logic [DW-1:0]         RDATA,
   output logic                  ERR,
   output logic                  BUSY,
   output logic                  TRANSFER,
   output logic                  READ_WRITE,
   output logic [AW-1:0]         PADDR_IN,
   output logic [DW-1:0]         PWDATA_IN,
   input  logic                  PSEL,
   input  logic                  PENABLE,
   input  logic                  PREADY,
   input  logic                  PSLVERR,
   input  logic [DW-1:0]         PRDATA
);

   localparam int PW = $clog2(NUM_REQ);

   arb_state_e         state_q, state_d;
   logic [PW-1:0]      ptr_q, ptr_d, idx_q, idx_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d, done_q, done_d;
   logic [DW-1:0]      rdata_q, rdata_d, wdata_q, wdata_d;
   logic [AW-1:0]      addr_q, addr_d;
   logic               err_q, err_d, busy_q, busy_d;
   logic               transfer_q, transfer_d, rw_q, rw_d;

   logic [PW-1:0]      pick_idx, sel_idx;
   logic [NUM_REQ-1:0] pick_gnt, sel_gnt;
   logic               apb_done, lock_hit, hold_ptr;

   assign apb_done = PSEL & PENABLE & PREADY;

   apb_rr_picker #(
      .NUM_REQ (NUM_REQ),
      .PW      (PW)
   ) u_picker (
      .req_i (REQ),
      .ptr_i (ptr_q),
      .gnt_o (pick_gnt),
      .idx_o (pick_idx)
   );

`ifdef APB_ARB_LOCK_EN
   logic lock_q, lock_d;

   // A held lock re-grants the previous winner while it keeps both REQ and REQ_LOCK high.
   assign lock_hit = lock_q & REQ[idx_q] & REQ_LOCK[idx_q];
   assign hold_ptr = lock_q;

   always_comb begin
      lock_d = lock_q;
      if (state_q == ST_IDLE && !lock_hit) lock_d = 1'b0;
      else if (state_q == ST_WAIT && apb_done) lock_d = REQ_LOCK[idx_q];
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) lock_q <= 1'b0;
      else          lock_q <= lock_d;
   end
`else
   logic unused_lock;
   assign unused_lock = ^REQ_LOCK;
   assign lock_hit    = 1'b0;
   assign hold_ptr    = 1'b0;
`endif

   assign sel_idx = lock_hit ? idx_q : pick_idx;
   assign sel_gnt = lock_hit ? (NUM_REQ'(1) << idx_q) : pick_gnt;

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      idx_d      = idx_q;
      gnt_d      = gnt_q;
      done_d     = done_q;
      rdata_d    = rdata_q;
      err_d      = err_q;
      busy_d     = busy_q;
      transfer_d = transfer_q;
      rw_d       = rw_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      case (state_q)
         ST_IDLE: begin
            if (|REQ) begin
               idx_d      = sel_idx;
               gnt_d      = sel_gnt;
               rw_d       = REQ_WRITE[sel_idx];
               addr_d     = REQ_ADDR[sel_idx*AW +: AW];
               wdata_d    = REQ_WDATA[sel_idx*DW +: DW];
               transfer_d = 1'b1;
               busy_d     = 1'b1;
               state_d    = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            transfer_d = 1'b0;
            state_d    = ST_WAIT;
         end
         ST_WAIT: begin
            if (apb_done) begin
               rdata_d = rw_q ? '0 : PRDATA;
               err_d   = PSLVERR;
               done_d  = gnt_q;
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            gnt_d   = '0;
            done_d  = '0;
            rdata_d = '0;
            err_d   = 1'b0;
            busy_d  = 1'b0;
            if (!hold_ptr) ptr_d = PW'(wrap_inc(32'(idx_q), NUM_REQ));
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q    <= ST_IDLE;
         ptr_q      <= '0;
         idx_q      <= '0;
         gnt_q      <= '0;
         done_q     <= '0;
         rdata_q    <= '0;
         err_q      <= 1'b0;
         busy_q     <= 1'b0;
         transfer_q <= 1'b0;
         rw_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         idx_q      <= idx_d;
         gnt_q      <= gnt_d;
         done_q     <= done_d;
         rdata_q    <= rdata_d;
         err_q      <= err_d;
         busy_q     <= busy_d;
         transfer_q <= transfer_d;
         rw_q       <= rw_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
      end
   end

   assign GNT        = gnt_q;
   assign DONE       = done_q;
   assign RDATA      = rdata_q;
   assign ERR        = err_q;
   assign BUSY       = busy_q;
   assign TRANSFER   = transfer_q;
   assign READ_WRITE = rw_q;
   assign PADDR_IN   = addr_q;
   assign PWDATA_IN  = wdata_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Self-checking bench for apb_req_arbiter: directed table, corner sequences, randomized traffic vs. model.
module tb_apb_req_arbiter;

   localparam int NUM_REQ = 4;
   localparam int AW      = 32;
   localparam int DW      = 32;
`ifdef APB_ARB_LOCK_EN
   localparam bit LOCK_EN = 1'b1;
`else
   localparam bit LOCK_EN = 1'b0;
`endif

   logic                  PCLK, PRESETn;
   logic [NUM_REQ-1:0]    REQ, REQ_WRITE, REQ_LOCK;
   logic [NUM_REQ*AW-1:0] REQ_ADDR;
   logic [NUM_REQ*DW-1:0] REQ_WDATA;
   logic [NUM_REQ-1:0]    GNT, DONE;
   logic [DW-1:0]         RDATA, PWDATA_IN, PRDATA;
   logic [AW-1:0]         PADDR_IN;
   logic                  ERR, BUSY, TRANSFER, READ_WRITE;
   logic                  PSEL, PENABLE, PREADY, PSLVERR;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state: rotation pointer and lock holder.
   int m_ptr      = 0;
   bit m_lock     = 1'b0;
   int m_lock_idx = 0;

   typedef struct {
      logic [NUM_REQ-1:0] req;
      logic               write;
      logic [31:0]        addr;
      logic [31:0]        wdata;
      int                 waits;
      logic               err;
      int                 exp_idx;
   } vec_t;

   vec_t vecs[7];

   apb_req_arbiter #(
      .NUM_REQ (NUM_REQ),
      .AW      (AW),
      .DW      (DW)
   ) dut (
      .PCLK       (PCLK),
      .PRESETn    (PRESETn),
      .REQ        (REQ),
      .REQ_WRITE  (REQ_WRITE),
      .REQ_ADDR   (REQ_ADDR),
      .REQ_WDATA  (REQ_WDATA),
      .REQ_LOCK   (REQ_LOCK),
      .GNT        (GNT),
      .DONE       (DONE),
      .RDATA      (RDATA),
      .ERR        (ERR),
      .BUSY       (BUSY),
      .TRANSFER   (TRANSFER),
      .READ_WRITE (READ_WRITE),
      .PADDR_IN   (PADDR_IN),
      .PWDATA_IN  (PWDATA_IN),
      .PSEL       (PSEL),
      .PENABLE    (PENABLE),
      .PREADY     (PREADY),
      .PSLVERR    (PSLVERR),
      .PRDATA     (PRDATA)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] slave_data(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   // Winner gets exactly (write, addr, wdata); every other requester gets distinct fields.
   task automatic set_fields(input logic write, input logic [31:0] addr, input logic [31:0] wdata,
                             input int winner);
      for (int i = 0; i < NUM_REQ; i++) begin
         REQ_ADDR[i*AW +: AW]  = addr + 32'(i * 256) - 32'(winner * 256);
         REQ_WDATA[i*DW +: DW] = wdata ^ (32'(i ^ winner) << 16);
         REQ_WRITE[i]          = write ^ (i != winner);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, " GNT"}, GNT, 0);
      check({tag, " DONE"}, DONE, 0);
      check({tag, " RDATA"}, RDATA, 0);
      check({tag, " ERR"}, ERR, 0);
      check({tag, " BUSY"}, BUSY, 0);
      check({tag, " TRANSFER"}, TRANSFER, 0);
      check({tag, " READ_WRITE"}, READ_WRITE, 0);
      check({tag, " PADDR_IN"}, PADDR_IN, 0);
      check({tag, " PWDATA_IN"}, PWDATA_IN, 0);
   endtask

   task automatic check_idle(input string tag);
      check({tag, " idle DONE"}, DONE, 0);
      check({tag, " idle BUSY"}, BUSY, 0);
      check({tag, " idle GNT"}, GNT, 0);
      check({tag, " idle TRANSFER"}, TRANSFER, 0);
   endtask

   // Plays apb_master + slave for one granted transfer. Entered at the IDLE negedge after REQ is set,
   // returns at the negedge inside RESP.
   task automatic run_txn(input string tag, input int exp_idx, input logic exp_wr,
                          input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                          input int waits, input logic err_in,
                          input bit scramble, input bit drop_early, input bit keep_req);
      int                 guard;
      logic [31:0]        exp_rd;
      logic [NUM_REQ-1:0] exp_gnt;
      guard   = 0;
      exp_gnt = NUM_REQ'(1) << exp_idx;
      exp_rd  = exp_wr ? 32'h0 : slave_data(exp_addr);
      @(negedge PCLK);
      while (!TRANSFER && guard < 20) begin
         @(negedge PCLK);
         guard++;
      end
      check({tag, " latency"}, guard, 0);
      if (!TRANSFER) return;
      check({tag, " GNT"}, GNT, exp_gnt);
      check({tag, " READ_WRITE"}, READ_WRITE, exp_wr);
      check({tag, " PADDR_IN"}, PADDR_IN, exp_addr);
      check({tag, " PWDATA_IN"}, PWDATA_IN, exp_wdata);
      check({tag, " issue BUSY"}, BUSY, 1);
      check({tag, " issue DONE"}, DONE, 0);
      PSEL   = 1'b1;
      PREADY = 1'b1;
      if (scramble) begin
         REQ_WRITE = NUM_REQ'($urandom);
         REQ_ADDR  = {$urandom, $urandom, $urandom, $urandom};
         REQ_WDATA = {$urandom, $urandom, $urandom, $urandom};
      end
      if (drop_early) REQ[exp_idx] = 1'b0;
      @(negedge PCLK);
      check({tag, " setup TRANSFER"}, TRANSFER, 0);
      check({tag, " setup DONE"}, DONE, 0);
      PENABLE = 1'b1;
      PREADY  = (waits == 0);
      PRDATA  = exp_wr ? $urandom : slave_data(exp_addr);
      PSLVERR = err_in;
      for (int w = 0; w < waits; w++) begin
         @(negedge PCLK);
         check({tag, " wait BUSY"}, BUSY, 1);
         check({tag, " wait DONE"}, DONE, 0);
         check({tag, " wait TRANSFER"}, TRANSFER, 0);
         if (w == waits - 1) PREADY = 1'b1;
      end
      @(negedge PCLK);
      check({tag, " DONE"}, DONE, exp_gnt);
      check({tag, " RDATA"}, RDATA, exp_rd);
      check({tag, " ERR"}, ERR, err_in);
      check({tag, " resp GNT"}, GNT, exp_gnt);
      check({tag, " resp PADDR_IN"}, PADDR_IN, exp_addr);
      PSEL    = 1'b0;
      PENABLE = 1'b0;
      PREADY  = 1'b0;
      PSLVERR = 1'b0;
      PRDATA  = '0;
      if (!keep_req) REQ[exp_idx] = 1'b0;
   endtask

   // Spec rule: a held lock wins outright; otherwise first set request from ptr, wrapping.
   task automatic model_pick(input logic [NUM_REQ-1:0] r, input logic [NUM_REQ-1:0] lk, output int w);
      w = -1;
      if (LOCK_EN && m_lock && r[m_lock_idx] && lk[m_lock_idx]) begin
         w = m_lock_idx;
      end else begin
         m_lock = 1'b0;
         for (int k = NUM_REQ - 1; k >= 0; k--)
            if (r[(m_ptr + k) % NUM_REQ]) w = (m_ptr + k) % NUM_REQ;
      end
   endtask

   task automatic model_commit(input int w, input logic lk_bit);
      m_lock     = LOCK_EN && lk_bit;
      m_lock_idx = w;
      if (!m_lock) m_ptr = (w + 1) % NUM_REQ;
   endtask

   task automatic apply_reset();
      PRESETn = 1'b0;
      REQ = '0; REQ_LOCK = '0;
      PSEL = 1'b0; PENABLE = 1'b0; PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
      repeat (2) @(negedge PCLK);
      check_zero("reset pulse");
      PRESETn = 1'b1;
      m_ptr   = 0;
      m_lock  = 1'b0;
   endtask

   initial begin
      vecs[0] = '{4'b0001, 1'b1, 32'h0000_0003, 32'h0000_0002, 0, 1'b0, 0};
      vecs[1] = '{4'b0100, 1'b0, 32'h0000_0005, 32'h0000_0000, 0, 1'b0, 2};
      vecs[2] = '{4'b0010, 1'b1, 32'h0000_0007, 32'hDEAD_BEEF, 3, 1'b0, 1};
      vecs[3] = '{4'b1011, 1'b0, 32'h0000_0009, 32'h0000_0000, 0, 1'b1, 3};
      vecs[4] = '{4'b1100, 1'b0, 32'h1234_5678, 32'h0000_0000, 1, 1'b0, 2};
      vecs[5] = '{4'b0101, 1'b1, 32'hFFFF_FFFC, 32'hA5A5_5A5A, 2, 1'b1, 0};
      vecs[6] = '{4'b1001, 1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 0, 1'b0, 3};

      PRESETn = 1'b0;
      REQ_LOCK = '0;
      PSEL = 1'b0; PENABLE = 1'b0; PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
      REQ = 4'b1111;
      for (int i = 0; i < NUM_REQ; i++) begin
         REQ_ADDR[i*AW +: AW]  = 32'h40 + 32'(i);
         REQ_WDATA[i*DW +: DW] = 32'hC0DE_0000 + 32'(i);
         REQ_WRITE[i]          = i[0];
      end
      repeat (3) @(negedge PCLK);
      check_zero("reset");
      PRESETn = 1'b1;

      // Contention from reset: every requester drops on its own DONE.
      for (int k = 0; k < NUM_REQ; k++) begin
         run_txn($sformatf("rr%0d", k), k, k[0], 32'h40 + 32'(k), 32'hC0DE_0000 + 32'(k),
                 0, 1'b0, 1'b0, 1'b0, 1'b0);
         @(negedge PCLK);
         check_idle($sformatf("rr%0d", k));
      end

      // Bus activity outside WAIT must not complete anything.
      PSEL = 1'b1; PENABLE = 1'b1; PREADY = 1'b1; PSLVERR = 1'b1;
      @(negedge PCLK);
      check("stray bus DONE", DONE, 0);
      check("stray bus BUSY", BUSY, 0);
      check("stray bus ERR", ERR, 0);
      PSEL = 1'b0; PENABLE = 1'b0; PREADY = 1'b0; PSLVERR = 1'b0;

      foreach (vecs[v]) begin
         REQ = vecs[v].req;
         set_fields(vecs[v].write, vecs[v].addr, vecs[v].wdata, vecs[v].exp_idx);
         run_txn($sformatf("vec%0d", v), vecs[v].exp_idx, vecs[v].write, vecs[v].addr,
                 vecs[v].wdata, vecs[v].waits, vecs[v].err, 1'b0, 1'b0, 1'b0);
         @(negedge PCLK);
         check_idle($sformatf("vec%0d", v));
      end

      // Reset during WAIT: first move ptr to 2, then abort requester 2 mid-transfer.
      REQ = 4'b0010;
      set_fields(1'b1, 32'h100, 32'h55, 1);
      run_txn("pre_rst", 1, 1'b1, 32'h100, 32'h55, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge PCLK);
      check_idle("pre_rst");
      REQ = 4'b0100;
      set_fields(1'b0, 32'h200, 32'h0, 2);
      @(negedge PCLK);
      check("rst issue TRANSFER", TRANSFER, 1);
      PSEL = 1'b1; PREADY = 1'b1;
      @(negedge PCLK);
      PENABLE = 1'b1; PREADY = 1'b0;
      @(negedge PCLK);
      check("rst wait BUSY", BUSY, 1);
      PRESETn = 1'b0;
      #1;
      check_zero("async reset");
      PSEL = 1'b0; PENABLE = 1'b0;
      REQ = 4'b0101;
      set_fields(1'b1, 32'h300, 32'h77, 0);
      @(negedge PCLK);
      PRESETn = 1'b1;
      run_txn("post_rst", 0, 1'b1, 32'h300, 32'h77, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge PCLK);
      check_idle("post_rst");
      REQ = '0;
      m_ptr  = 1;
      m_lock = 1'b0;

      // Randomized traffic against the reference model.
      for (int t = 0; t < 40; t++) begin
         int                 w;
         logic               exp_wr;
         logic [31:0]        exp_addr, exp_wdata;
         logic [NUM_REQ-1:0] r;
         r         = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
         REQ       = r;
         REQ_WRITE = NUM_REQ'($urandom);
         REQ_ADDR  = {$urandom, $urandom, $urandom, $urandom};
         REQ_WDATA = {$urandom, $urandom, $urandom, $urandom};
         REQ_LOCK  = NUM_REQ'($urandom);
         model_pick(r, REQ_LOCK, w);
         exp_wr    = REQ_WRITE[w];
         exp_addr  = REQ_ADDR[w*AW +: AW];
         exp_wdata = REQ_WDATA[w*DW +: DW];
         run_txn($sformatf("rnd%0d", t), w, exp_wr, exp_addr, exp_wdata,
                 $urandom_range(0, 3), 1'($urandom), 1'b1, ($urandom_range(0, 3) == 0), 1'b0);
         model_commit(w, REQ_LOCK[w]);
         @(negedge PCLK);
         check_idle($sformatf("rnd%0d", t));
      end

`ifdef APB_ARB_LOCK_EN
      // Locked requester 1 beats requester 0 until it drops REQ_LOCK.
      apply_reset();
      REQ = 4'b0010; REQ_LOCK = 4'b0010;
      set_fields(1'b1, 32'h60, 32'h1, 1);
      run_txn("lock0", 1, 1'b1, 32'h60, 32'h1, 0, 1'b0, 1'b0, 1'b0, 1'b1);
      @(negedge PCLK);
      check_idle("lock0");
      REQ = 4'b0011;
      set_fields(1'b1, 32'h64, 32'h2, 1);
      run_txn("lock1", 1, 1'b1, 32'h64, 32'h2, 1, 1'b0, 1'b0, 1'b0, 1'b1);
      @(negedge PCLK);
      check_idle("lock1");
      REQ = 4'b0011; REQ_LOCK = 4'b0000;
      set_fields(1'b0, 32'h68, 32'h0, 0);
      run_txn("lock2", 0, 1'b0, 32'h68, 32'h0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge PCLK);
      check_idle("lock2");
      REQ = '0;
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
